// File: rtl/post_box_pulse_decoder.sv
// ---------------------------------------------------------------------------
// post_box_pulse_decoder
//
// Front end of the POST box target link. The raw testreq_3v line is
// synchronised, then deglitched and qualified. The block counts the accepted
// high pulses within a burst and detects the long low that separates bursts.
// The downstream protocol FSM gets a strobe per accepted pulse, a strobe per
// falling edge, and an end-of-burst strobe that carries the burst length.
//
// Ports
//   fpga_clock_48mhz  in   sole clock, 48MHz
//   reset_in_n        in   asynchronous active-low reset (released synchronously)
//   testreq_3v        in   raw asynchronous request line from the target
//   req_level         out  deglitched request level
//   pulse_strobe      out  1-cycle strobe when a high pulse is qualified
//   fall_strobe       out  1-cycle strobe on the falling edge of a qualified pulse
//   pulse_count       out  running pulse count of the current burst (saturating)
//   burst_done        out  1-cycle strobe when the inter-burst break is seen
//   burst_count       out  pulse count of the last completed burst
//   busy              out  burst in progress
//   overflow          out  pulse count saturated in the current/last burst
//
// Optional feature (macro POSTBOX_PULSE_STATS_EN):
//   stat_pulses[15:0]   total accepted pulses (wraps)
//   stat_bursts[15:0]   total completed bursts (wraps)
//   stat_glitches[7:0]  total rejected qualifications (saturates at 255)
// ---------------------------------------------------------------------------
module post_box_pulse_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 6,
    parameter int BREAK_CYCLES  = 960,
    parameter int CNT_W         = 4
) (
    input  logic             fpga_clock_48mhz,
    input  logic             reset_in_n,
    input  logic             testreq_3v,
    output logic             req_level,
    output logic             pulse_strobe,
    output logic             fall_strobe,
    output logic [CNT_W-1:0] pulse_count,
    output logic             burst_done,
    output logic [CNT_W-1:0] burst_count,
    output logic             busy,
`ifdef POSTBOX_PULSE_STATS_EN
    output logic [15:0]      stat_pulses,
    output logic [15:0]      stat_bursts,
    output logic [7:0]       stat_glitches,
`endif
    output logic             overflow
);

    localparam int HW = $clog2(GLITCH_CYCLES + 1);
    localparam int GW = $clog2(BREAK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [HW-1:0]    HCNT_LAST = HW'(GLITCH_CYCLES - 1);
    localparam logic [GW-1:0]    GCNT_LAST = GW'(BREAK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        HIGH,
        GAP
    } state_t;

    // Reset release is re-timed to the clock so every flop leaves reset on the
    // same edge; assertion still takes effect immediately.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge fpga_clock_48mhz or negedge reset_in_n) begin
        if (!reset_in_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   req_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], testreq_3v};
    assign req_s  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge fpga_clock_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    state_t          state_q;
    logic [HW-1:0]   hcnt_q;
    logic [GW-1:0]   gcnt_q;

    // hcnt_q counts synchronised high samples in the current run, including
    // the one that caused entry to QUAL. gcnt_q counts low-side clocks since
    // the last qualified fall, including the fall clock itself, so a break
    // fires on the BREAK_CYCLES-th such clock. It keeps counting while a
    // glitch is being rejected, so glitches neither extend nor restart a gap.
    always_ff @(posedge fpga_clock_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hcnt_q        <= '0;
            gcnt_q        <= '0;
            req_level     <= 1'b0;
            pulse_strobe  <= 1'b0;
            fall_strobe   <= 1'b0;
            pulse_count   <= '0;
            burst_done    <= 1'b0;
            burst_count   <= '0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
`ifdef POSTBOX_PULSE_STATS_EN
            stat_pulses   <= '0;
            stat_bursts   <= '0;
            stat_glitches <= '0;
`endif
        end else begin
            pulse_strobe <= 1'b0;
            fall_strobe  <= 1'b0;
            burst_done   <= 1'b0;

            if (busy && (state_q != HIGH) && (gcnt_q < GCNT_LAST)) begin
                gcnt_q <= gcnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        state_q <= QUAL;
                        hcnt_q  <= HW'(1);
                    end
                end

                QUAL: begin
                    if (!req_s) begin
                        // Rejected glitch: go back to whichever low state we came from.
                        state_q <= busy ? GAP : IDLE;
`ifdef POSTBOX_PULSE_STATS_EN
                        if (stat_glitches != 8'hFF) begin
                            stat_glitches <= stat_glitches + 1'b1;
                        end
`endif
                    end else if (hcnt_q == HCNT_LAST) begin
                        state_q      <= HIGH;
                        pulse_strobe <= 1'b1;
                        req_level    <= 1'b1;
                        busy         <= 1'b1;
`ifdef POSTBOX_PULSE_STATS_EN
                        stat_pulses  <= stat_pulses + 1'b1;
`endif
                        if (!busy) begin
                            // First pulse of a new burst restarts the count and
                            // drops the previous burst's overflow flag.
                            pulse_count <= CNT_W'(1);
                            overflow    <= 1'b0;
                        end else if (pulse_count == CNT_MAX) begin
                            overflow    <= 1'b1;
                        end else begin
                            pulse_count <= pulse_count + 1'b1;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                    end
                end

                HIGH: begin
                    if (!req_s) begin
                        state_q     <= GAP;
                        fall_strobe <= 1'b1;
                        req_level   <= 1'b0;
                        gcnt_q      <= GW'(1);
                    end
                end

                GAP: begin
                    if (req_s) begin
                        state_q <= QUAL;
                        hcnt_q  <= HW'(1);
                    end else if (gcnt_q >= GCNT_LAST) begin
                        state_q     <= IDLE;
                        burst_done  <= 1'b1;
                        burst_count <= pulse_count;
                        pulse_count <= '0;
                        busy        <= 1'b0;
`ifdef POSTBOX_PULSE_STATS_EN
                        stat_bursts <= stat_bursts + 1'b1;
`endif
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
